// File: rtl/buffer_pkg.sv
// Shared types for the convolution set buffer and its write-side loader.
// Word/set typedefs and the loader FSM state encoding.
package buffer_pkg;
   localparam int DATA_WIDTH  = 32;
   localparam int DATA_OF_SET = 128;
   localparam int NUM_OF_MUL  = DATA_OF_SET;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef data_t [DATA_OF_SET-1:0] set_t;

   typedef enum logic {
      FILL,
      SEND
   } loader_state_e;
endpackage

// File: rtl/buffer_loader_if.sv
// Beat stream in, set write port out, between DMA reader and set buffer.
// master: stream source / buffer side; slave: the loader.
interface buffer_loader_if #(
   parameter int BEAT_WORDS = 4,
   parameter int CNT_WIDTH  = 16
);
   import buffer_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   data_t [BEAT_WORDS-1:0]  in_data;
   logic                    in_last;
   logic                    full_flag;
   logic                    wen;
   set_t                    din;
   logic                    busy;
   logic [CNT_WIDTH-1:0]    set_count;

   modport master (
      output in_valid, in_data, in_last, full_flag,
      input  in_ready, wen, din, busy, set_count
   );

   modport slave (
      input  in_valid, in_data, in_last, full_flag,
      output in_ready, wen, din, busy, set_count
   );
endinterface

// File: rtl/set_packer.sv
// Staging register and beat counter: writes beat k to words k*BEAT_WORDS+j.
// With BUFFER_LOADER_PAD_EN, in_last zero-fills the remainder and ends the set.
module set_packer
   import buffer_pkg::*;
#(
   parameter int BEAT_WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en_i,
   input  data_t [BEAT_WORDS-1:0] beat_i,
   input  logic                   last_i,
   input  logic                   clr_i,
   output set_t                   set_o,
   output logic                   done_o,
   output logic                   busy_o
);
   localparam int NB = DATA_OF_SET / BEAT_WORDS;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam int IW = $clog2(DATA_OF_SET);
   localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

   logic [KW-1:0] k_q, k_d;
   set_t          set_q, set_d;
   logic [IW-1:0] base;
   logic          fin;

   assign base = IW'(k_q) * IW'(BEAT_WORDS);

`ifdef BUFFER_LOADER_PAD_EN
   assign fin = (k_q == K_LAST) || last_i;
`else
   logic unused_last;
   assign unused_last = last_i;
   assign fin = (k_q == K_LAST);
`endif

   always_comb begin
      set_d = set_q;
      k_d   = k_q;
      if (clr_i) set_d = '0;
      if (wr_en_i) begin
         for (int j = 0; j < BEAT_WORDS; j++)
            set_d[base + IW'(j)] = beat_i[j];
`ifdef BUFFER_LOADER_PAD_EN
         // words past this beat are stale or leftover; blank them
         for (int i = 0; i < DATA_OF_SET; i++)
            if (last_i && i >= int'(base) + BEAT_WORDS)
               set_d[IW'(i)] = '0;
`endif
         k_d = fin ? '0 : k_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q   <= '0;
         set_q <= '0;
      end else begin
         k_q   <= k_d;
         set_q <= set_d;
      end
   end

   assign set_o  = set_q;
   assign done_o = wr_en_i && fin;
   assign busy_o = (k_q != '0);
endmodule

// File: rtl/buffer_loader.sv
// Packs beats into sets and commits each set with one wen pulse.
// Optional BUFFER_LOADER_PAD_EN: in_last pads and closes a short set.
module buffer_loader
   import buffer_pkg::*;
#(
   parameter int BEAT_WORDS = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic            clk,
   input  logic            rst,
   buffer_loader_if.slave  bus
);
   loader_state_e        state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 run_q;
   logic                 ready;
   logic                 accept;
   logic                 wen;
   logic                 clr;
   logic                 done;
   logic                 fill_busy;

   // run_q keeps in_ready low until the first edge after reset release
   assign ready  = run_q && (state_q == FILL);
   assign accept = bus.in_valid && ready;

`ifdef BUFFER_LOADER_PAD_EN
   assign clr = wen;
`else
   assign clr = 1'b0;
`endif

   set_packer #(
      .BEAT_WORDS (BEAT_WORDS)
   ) u_packer (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (accept),
      .beat_i  (bus.in_data),
      .last_i  (bus.in_last),
      .clr_i   (clr),
      .set_o   (bus.din),
      .done_o  (done),
      .busy_o  (fill_busy)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen     = 1'b0;
      unique case (state_q)
         FILL: begin
            if (done) state_d = SEND;
         end
         SEND: begin
            wen = !bus.full_flag;
            if (wen) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.wen       = wen;
   assign bus.busy      = (state_q == SEND) || fill_busy;
   assign bus.set_count = cnt_q;
endmodule

// File: doc/buffer_loader.md
# buffer_loader

Write-side front end for the convolution accelerator's set buffer. Accepts a narrow valid/ready stream of data words from the memory side, packs `DATA_OF_SET` words into one staging set, and commits each completed set to the buffer with a single-cycle `wen` pulse, honouring `full_flag` back-pressure. Sits between the DMA/memory reader and the buffer's `wen`/`din`/`full_flag` port; the buffer's read side (`ren`/`dout`) is untouched.

## Interface
- `DATA_WIDTH`, 32, bits per word
- `DATA_OF_SET`, 128, words per set, equal to the buffer's `din` width in words
- `BEAT_WORDS`, 4, words per input beat; `DATA_OF_SET % BEAT_WORDS == 0` is required
- `CNT_WIDTH`, 16, width of the committed-set counter
- `clk`  in  1  clock, all logic on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  loader can accept a beat
- `in_data`  in  `[BEAT_WORDS-1:0][DATA_WIDTH-1:0]`  input beat
- `in_last`  in  1  final beat of a transfer (used only with `BUFFER_LOADER_PAD_EN`)
- `full_flag`  in  1  buffer full, from the buffer
- `wen`  out  1  buffer write enable, one cycle per committed set
- `din`  out  `[DATA_OF_SET-1:0][DATA_WIDTH-1:0]`  set presented to the buffer
- `busy`  out  1  staging register holds at least one beat or a pending set
- `set_count`  out  `CNT_WIDTH`  number of sets committed since reset, wraps

## Operation
- Two-state FSM: `FILL`, `SEND`. Reset state `FILL`.
- `FILL`: `in_ready = 1`. A beat transfers when `in_valid && in_ready`. Beat index `k` (0..`DATA_OF_SET/BEAT_WORDS-1`) writes `in_data[j]` to staging word `k*BEAT_WORDS + j`. On acceptance of beat index `DATA_OF_SET/BEAT_WORDS-1`: beat counter clears, go to `SEND`.
- `SEND`: `in_ready = 0`. `wen = !full_flag` (combinational). On a cycle with `wen = 1`: `set_count` increments (mod 2^`CNT_WIDTH`), go to `FILL`. While `full_flag = 1`, hold in `SEND`, `din` stable.
- `din` is driven directly from the staging register at all times; it is valid only while `wen = 1`.
- `busy = (state == SEND) || (beat counter != 0)`.
- `in_valid` while `in_ready = 0` is ignored; the source holds the beat per valid/ready rules.

## Timing
- Reset values (while `rst` low and immediately after): `in_ready = 0` during reset, `1` from the first cycle after release; `wen = 0`, `busy = 0`, `set_count = 0`, staging register and `din` all zero, beat counter 0.
- Latency: last beat accepted at edge N; `wen` high in cycle N+1 if `full_flag = 0` at that time. Earliest next beat accepted at the edge ending the `wen` cycle + 1, i.e. one bubble cycle per set.
- `full_flag` rising in the same cycle as entry to `SEND`: no write; wait.
- `full_flag` changing mid-`SEND`: `wen` follows it combinationally; exactly one write per set.
- Reset asserted mid-fill or mid-`SEND`: partial/pending set discarded, no `wen`, all outputs to reset values asynchronously.
- `set_count` at all-ones wraps to 0 on the next commit.

## Configuration
- `BUFFER_LOADER_PAD_EN` defined: a beat accepted with `in_last = 1` that is not the final beat of a set zero-fills all remaining staging words (same edge) and moves to `SEND`; `in_last` on the final beat behaves as a normal final beat. The next set starts at beat 0 with a cleared staging register.
- Undefined: `in_last` is ignored; sets are committed only when complete; staging register is not cleared between sets.

## Structure
- Shared package `buffer_pkg`: `DATA_WIDTH`, `DATA_OF_SET`, `NUM_OF_MUL` constants, word typedef `data_t`, set typedef `set_t`, and loader state enum `loader_state_e` (`FILL`, `SEND`).
- One sub-module: `set_packer` (staging register + beat counter, write-by-index, clear, full-indication); FSM, `wen`, and `set_count` stay in `buffer_loader`.

## Test plan
- Reset: hold `rst = 0`, drive `in_valid = 1` -> `in_ready = 0`, `wen = 0`, `set_count = 0`; release -> `in_ready = 1` next cycle.
- Single set: 32 beats of values 0..127 back-to-back, `full_flag = 0` -> `wen` high exactly one cycle after last beat, `din[i] = i` for all i, `set_count = 1`.
- Back-pressure: `full_flag = 1` at set completion for 10 cycles -> `wen = 0`, `in_ready = 0`, `din` stable; drop `full_flag` -> one `wen` pulse, then `in_ready = 1`.
- Stalling source: random `in_valid` gaps over 3 sets -> 3 `wen` pulses, word order correct, `set_count = 3`.
- Reset mid-fill after 17 beats -> no `wen`; next full set of 32 beats commits only new data.
- With `BUFFER_LOADER_PAD_EN`: 5 beats, `in_last` on beat 5 -> `wen` next cycle, `din[0..19]` = data, `din[20..127] = 0`.
